// File: rtl/imem_boot_loader_if.sv
// Loader link (byte stream in) and instruction-memory write port of the boot loader.
// The slave side is the loader; the master side is the link source / memory model.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot/reload controller: receives a length-prefixed big-endian byte stream, writes the
// words into instruction memory and holds the core in reset until the load completes.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  imem_boot_loader_if.slave     io_bus,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH:0]   o_words_loaded
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]            r_state,        w_state_nxt;
  logic [15:0]           r_len,          w_len_nxt;
  logic [1:0]            r_byte_idx,     w_byte_idx_nxt;
  logic [23:0]           r_shift,        w_shift_nxt;
  logic [TW-1:0]         r_tmo,          w_tmo_nxt;
  logic                  r_rx_ready,     w_rx_ready_nxt;
  logic                  r_imem_we,      w_imem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_imem_addr,    w_imem_addr_nxt;
  logic [31:0]           r_imem_wdata,   w_imem_wdata_nxt;
  logic                  r_cpu_rst,      w_cpu_rst_nxt;
  logic                  r_busy,         w_busy_nxt;
  logic                  r_done,         w_done_nxt;
  logic                  r_err,          w_err_nxt;
  logic [CW-1:0]         r_words_loaded, w_words_loaded_nxt;

  logic                  w_accept;
  logic [15:0]           w_hdr_len;
  logic                  w_len_bad;
  logic                  w_last_word;
  logic                  w_tmo_hit;
  logic [31:0]           w_word;

  assign w_accept    = io_bus.rx_valid & r_rx_ready;
  assign w_hdr_len   = {r_len[15:8], io_bus.rx_data};
  assign w_len_bad   = (w_hdr_len == 16'd0) || (32'(w_hdr_len) > DEPTH);
  assign w_last_word = (32'(r_words_loaded) + 32'd1) == 32'(r_len);
  assign w_tmo_hit   = (32'(r_tmo) + 32'd1) >= TIMEOUT_CYCLES;
  assign w_word      = {r_shift, io_bus.rx_data};

  // State and output registers; memory contents are never touched by reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_byte_idx     <= '0;
      r_shift        <= '0;
      r_tmo          <= '0;
      r_rx_ready     <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_cpu_rst      <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_len          <= w_len_nxt;
      r_byte_idx     <= w_byte_idx_nxt;
      r_shift        <= w_shift_nxt;
      r_tmo          <= w_tmo_nxt;
      r_rx_ready     <= w_rx_ready_nxt;
      r_imem_we      <= w_imem_we_nxt;
      r_imem_addr    <= w_imem_addr_nxt;
      r_imem_wdata   <= w_imem_wdata_nxt;
      r_cpu_rst      <= w_cpu_rst_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_err          <= w_err_nxt;
      r_words_loaded <= w_words_loaded_nxt;
    end
  end

  // Next-state and next-output logic; an accept always wins over the timeout.
  always_comb begin
    w_state_nxt        = r_state;
    w_len_nxt          = r_len;
    w_byte_idx_nxt     = r_byte_idx;
    w_shift_nxt        = r_shift;
    w_tmo_nxt          = r_tmo;
    w_rx_ready_nxt     = r_rx_ready;
    w_imem_we_nxt      = 1'b0;
    w_imem_addr_nxt    = r_imem_addr;
    w_imem_wdata_nxt   = r_imem_wdata;
    w_cpu_rst_nxt      = r_cpu_rst;
    w_busy_nxt         = r_busy;
    w_done_nxt         = r_done;
    w_err_nxt          = r_err;
    w_words_loaded_nxt = r_words_loaded;

    case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (i_start) begin
          w_state_nxt        = S_HDR;
          w_len_nxt          = '0;
          w_byte_idx_nxt     = '0;
          w_tmo_nxt          = '0;
          w_words_loaded_nxt = '0;
          w_rx_ready_nxt     = 1'b1;
          w_cpu_rst_nxt      = 1'b1;
          w_busy_nxt         = 1'b1;
          w_done_nxt         = 1'b0;
          w_err_nxt          = 1'b0;
        end
      end

      S_HDR: begin
        if (w_accept) begin
          w_tmo_nxt = '0;
          if (r_byte_idx == 2'd0) begin
            w_len_nxt      = {io_bus.rx_data, 8'h00};
            w_byte_idx_nxt = 2'd1;
          end else begin
            w_len_nxt      = w_hdr_len;
            w_byte_idx_nxt = 2'd0;
            if (w_len_bad) begin
              w_state_nxt    = S_ERR;
              w_err_nxt      = 1'b1;
              w_busy_nxt     = 1'b0;
              w_rx_ready_nxt = 1'b0;
            end else begin
              w_state_nxt = S_LOAD;
            end
          end
        end else if (w_tmo_hit) begin
          w_state_nxt    = S_ERR;
          w_err_nxt      = 1'b1;
          w_busy_nxt     = 1'b0;
          w_rx_ready_nxt = 1'b0;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          w_tmo_nxt      = '0;
          w_shift_nxt    = w_word[23:0];
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_imem_we_nxt      = 1'b1;
            w_imem_addr_nxt    = r_words_loaded[ADDR_WIDTH-1:0];
            w_imem_wdata_nxt   = w_word;
            w_words_loaded_nxt = r_words_loaded + CW'(1);
            if (w_last_word) begin
              w_state_nxt    = S_FLUSH;
              w_rx_ready_nxt = 1'b0;
            end
          end
        end else if (w_tmo_hit) begin
          // A partially assembled word is dropped here and never written.
          w_state_nxt    = S_ERR;
          w_err_nxt      = 1'b1;
          w_busy_nxt     = 1'b0;
          w_rx_ready_nxt = 1'b0;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end

      S_FLUSH: begin
        w_state_nxt    = S_RUN;
        w_rx_ready_nxt = 1'b0;
        w_cpu_rst_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b1;
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_rx_ready_nxt = 1'b0;
        w_cpu_rst_nxt  = 1'b1;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
      end
    endcase
  end

  assign io_bus.rx_ready   = r_rx_ready;
  assign io_bus.imem_we    = r_imem_we;
  assign io_bus.imem_addr  = r_imem_addr;
  assign io_bus.imem_wdata = r_imem_wdata;
  assign o_cpu_rst         = r_cpu_rst;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_err             = r_err;
  assign o_words_loaded    = r_words_loaded;

  // Structural invariants of the status outputs.
  a_we_only_busy: assert property (@(posedge i_clk) disable iff (!i_rst) r_imem_we |-> r_busy);
  a_done_err_excl: assert property (@(posedge i_clk) disable iff (!i_rst) !(r_done && r_err));
  a_run_released: assert property (@(posedge i_clk) disable iff (!i_rst) r_done |-> !r_cpu_rst);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: header table plus hand-written load, backpressure,
// timeout, reload and async-reset sequences, with a write scoreboard.
module tb_imem_boot_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 1000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    string       name;
    logic [15:0] n;
    logic        exp_err;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int total;
  int bad;
  wr_t sb[$];
  vec_t vecs[6];

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_boot_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_start        (start),
    .io_bus         (bus),
    .o_cpu_rst      (cpu_rst),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err),
    .o_words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; sample just after the edge and score any memory write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = sb.pop_front();
        check("we_addr", 64'(bus.imem_addr), 64'(e.addr));
        check("we_data", 64'(bus.imem_wdata), 64'(e.data));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    logic acc;
    acc = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (gap) tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rdy = bus.rx_ready;
      tick();
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    bus.rx_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_wait: byte 0x%0h got no ready expected accept", b);
    end
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w, input int gap);
    sb.push_back('{addr, w});
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after the last byte's edge: FLUSH now, RUN one edge later.
  task automatic finish_load(input int n);
    check("flush_cpu_rst", 64'(cpu_rst), 64'd1);
    check("flush_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("flush_words", 64'(words_loaded), 64'(n));
    tick();
    check("run_cpu_rst", 64'(cpu_rst), 64'd0);
    check("run_done", 64'(done), 64'd1);
    check("run_busy", 64'(busy), 64'd0);
    check("run_err", 64'(err), 64'd0);
    check("run_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int at;
    logic [15:0] n;

    vecs[0] = '{"n0",    16'h0000, 1'b1};
    vecs[1] = '{"n257",  16'h0101, 1'b1};
    vecs[2] = '{"nffff", 16'hFFFF, 1'b1};
    vecs[3] = '{"n1",    16'h0001, 1'b0};
    vecs[4] = '{"n256",  16'h0100, 1'b0};
    vecs[5] = '{"n3",    16'h0003, 1'b0};

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;

    #12;
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_rx_ready", 64'(bus.rx_ready), 64'd0);

    // Nominal two-word load at one byte per cycle.
    pulse_start();
    check("hdr_busy", 64'(busy), 64'd1);
    check("hdr_rx_ready", 64'(bus.rx_ready), 64'd1);
    check("hdr_cpu_rst", 64'(cpu_rst), 64'd1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(AW'(0), 32'h2008_0005, 0);
    send_word(AW'(1), 32'h2009_000A, 0);
    finish_load(2);

    // Reload from RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    check("reload_done", 64'(done), 64'd0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(AW'(0), 32'h0000_0000, 0);
    finish_load(1);

    // Header table: bad lengths abort, good lengths load random words.
    foreach (vecs[v]) begin
      pulse_start();
      check({vecs[v].name, "_start_err"}, 64'(err), 64'd0);
      n = vecs[v].n;
      send_byte(n[15:8], 0);
      send_byte(n[7:0], 0);
      if (vecs[v].exp_err) begin
        check({vecs[v].name, "_err"}, 64'(err), 64'd1);
        check({vecs[v].name, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({vecs[v].name, "_busy"}, 64'(busy), 64'd0);
        check({vecs[v].name, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
        tick();
        check({vecs[v].name, "_words"}, 64'(words_loaded), 64'd0);
      end else begin
        for (int k = 0; k < int'(n); k++) send_word(AW'(k), $urandom, 0);
        finish_load(int'(n));
      end
    end

    // Backpressure: alternating valid and a 50-cycle hole mid-word.
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    sb.push_back('{AW'(0), 32'h2008_0005});
    send_byte(8'h20, 1);
    send_byte(8'h08, 1);
    send_byte(8'h00, 50);
    send_byte(8'h05, 1);
    send_word(AW'(1), 32'h2009_000A, 1);
    finish_load(2);

    // Accept landing exactly on the timeout edge must not raise err.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    repeat (TMO - 1) tick();
    check("pre_timeout_err", 64'(err), 64'd0);
    sb.push_back('{AW'(0), 32'h1234_5678});
    send_byte(8'h12, 0);
    check("edge_accept_err", 64'(err), 64'd0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    finish_load(1);

    // Timeout mid-word.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    at = -1;
    for (int i = 1; i <= int'(TMO) + 50; i++) begin
      tick();
      if (err === 1'b1) begin
        at = i;
        break;
      end
    end
    check("timeout_cycles", 64'(at), 64'(TMO));
    check("timeout_words", 64'(words_loaded), 64'd0);
    check("timeout_cpu_rst", 64'(cpu_rst), 64'd1);
    check("timeout_busy", 64'(busy), 64'd0);

    // Asynchronous reset after five bytes of a load.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("arst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_we", 64'(bus.imem_we), 64'd0);
    check("arst_words", 64'(words_loaded), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    #12;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_arst_busy", 64'(busy), 64'd0);
    check("post_arst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("post_arst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("post_arst_done", 64'(done), 64'd0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(AW'(0), 32'hCAFE_F00D, 0);
    finish_load(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot/reload controller for the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready port, assembles big-endian 32-bit words and writes them into instruction memory. It holds the core in reset while loading and releases it once the last word has been written. It sits between the external loader link, the instruction-memory write port and the core's reset input.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words
TIMEOUT_CYCLES, 1000, number of idle cycles without an accepted byte (in HDR/LOAD) before the load aborts

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a load from IDLE, RUN or ERR
rx_valid  in  1  byte available on rx_data
rx_data  in  8  program byte; header first, then words MSB-first
rx_ready  out  1  block accepts a byte this cycle; transfer occurs when rx_valid & rx_ready
imem_we  out  1  instruction-memory write strobe, one cycle per word
imem_addr  out  ADDR_WIDTH  word address for the write
imem_wdata  out  32  assembled instruction word
cpu_rst  out  1  active-high reset to the core; 1 holds the core in reset
busy  out  1  1 while in HDR, LOAD or FLUSH
done  out  1  1 in RUN
err  out  1  1 in ERR
words_loaded  out  ADDR_WIDTH+1  count of words written in the current load

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE; rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, words_loaded=0; internal counters cleared.
- IDLE: cpu_rst=1, rx_ready=0.
  - start -> HDR; clear words_loaded, byte index and timeout counter.
- HDR: rx_ready=1.
  - First accepted byte is N[15:8]; second is N[7:0].
  - On the edge accepting the second byte: if N==0 or N>2**ADDR_WIDTH -> ERR; otherwise -> LOAD.
- LOAD: rx_ready=1. Each accepted byte shifts into the word register MSB-first (the first byte of a word lands in [31:24]).
  - On the edge accepting the 4th byte of word k: imem_we<=1, imem_addr<=k, imem_wdata<=assembled word, words_loaded<=k+1.
  - imem_we is high for exactly one cycle unless the next word also completes on the following edge.
  - Throughput is one byte per cycle; rx_valid gaps are tolerated.
  - If k==N-1: -> FLUSH and rx_ready<=0.
- FLUSH (1 cycle): imem_we high for the last word, cpu_rst=1.
  - Next edge -> RUN with imem_we<=0 and cpu_rst<=0, so the core leaves reset 2 edges after the last byte is accepted.
- RUN: done=1, cpu_rst=0, rx_ready=0.
  - start -> HDR; cpu_rst<=1 on the same edge; done<=0; previous memory contents are overwritten progressively.
- ERR: err=1, cpu_rst=1, rx_ready=0, imem_we=0. A partially assembled word is never written.
  - start -> HDR; clears err.
- Timeout: counter clears on state entry and on every accepted byte, and increments each HDR/LOAD cycle without an accepted byte. Reaching TIMEOUT_CYCLES -> ERR.
- start is ignored in HDR, LOAD and FLUSH.
- An accept coinciding with the timeout edge counts as an accept; no error is raised.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- rst asserted mid-load aborts immediately to reset values. Memory words already written are not cleared.

Test Plan:
1. Nominal load: start; bytes 00 02 20 08 00 05 20 09 00 0A at 1/cycle.
   - Required: imem_we at addr 0 with 0x20080005, then addr 1 with 0x2009000A; words_loaded=2.
   - Required: cpu_rst falls 2 edges after the last byte; done=1, busy=0.
2. Header errors:
   - N=0x0000 -> err=1 after the 2nd byte, no imem_we, cpu_rst stays 1.
   - N=0x0101 (ADDR_WIDTH=8) -> err=1.
   - Then start plus valid N=1 -> clean load, err=0.
3. Backpressure: same stream as test 1 with rx_valid toggling every other cycle and a 50-cycle gap mid-word.
   - Required: identical writes to test 1; no timeout.
4. Timeout (TIMEOUT_CYCLES=1000): header N=1, then bytes 20 08, then idle.
   - Required: err=1 exactly 1000 cycles after the last accept; no imem_we; words_loaded=0.
5. Reload from RUN: after test 1, pulse start.
   - Required: cpu_rst=1 on the next edge; load N=1 word 0x00000000 writes addr 0; RUN re-entered with words_loaded=1.
6. Async reset mid-LOAD: drive rst=0 between clock edges after 5 bytes.
   - Required: all outputs at reset values immediately (cpu_rst=1, rx_ready=0); after release, state=IDLE.
